// File: rtl/zpu_irq_ctrl_pkg.sv
// Shared definitions for the ZPU interrupt controller: register map,
// controller state encoding and the priority pick helper.
package zpu_irq_ctrl_pkg;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_VECBASE = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Each source owns a 32-byte slot above the vector base.
    localparam int VEC_SHIFT = 5;

    // Edges after reset release needed before the history flops are trustworthy.
    localparam int SETTLE_CYCLES = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    // Lowest set bit wins; index 0 is the highest priority.
    function automatic logic [3:0] lowest_set(input logic [15:0] vec);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) res = 4'(i);
        end
        return res;
    endfunction

endpackage

// File: rtl/zpu_irq_ctrl_edge.sv
// One interrupt source: two-flop synchronizer plus a history flop.
// rise is high for one cycle when the synchronized level goes 0 -> 1.
module irq_edge_sync
    import zpu_irq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic hist;

    // Synchronize the asynchronous source and keep one cycle of history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= src;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;

endmodule

// File: rtl/zpu_irq_ctrl.sv
// ZPU interrupt controller: edge-triggered sources, enable/pending
// registers on a Wishbone slave, and a request/service handshake with the core.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no request outstanding; picks the best enabled pending source
//   ST_REQ     | cpu_irq high, vector latched, waiting for interrutack
//   ST_SERVICE | core is running the handler, waiting for exitint
module zpu_irq_ctrl
    import zpu_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int pc_bit_size = 25,
    parameter int VEC_RESET   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     irq_src,
    output logic                   cpu_irq,
    output logic [pc_bit_size-1:0] interuptadr,
    input  logic                   interrutack,
    input  logic                   exitint,
    input  logic [1:0]             wb_adr_s,
    input  logic [31:0]            wb_dat_i,
    output logic [31:0]            wb_dat_o,
    input  logic                   wb_we_s,
    input  logic                   wb_stb_s,
    input  logic                   wb_cyc_s,
    output logic                   wb_ack_s
);

    logic [NUM_SRC-1:0]     rise;
    logic [NUM_SRC-1:0]     enable;
    logic [NUM_SRC-1:0]     pending;
    logic [NUM_SRC-1:0]     pending_nxt;
    logic [NUM_SRC-1:0]     ack_mask;
    logic [pc_bit_size-1:0] vecbase;
    logic [pc_bit_size-1:0] vec_nxt;
    logic [15:0]            req_vec;
    logic [3:0]             idx;
    logic [3:0]             idx_nxt;
    logic [1:0]             settle_cnt;
    logic                   edge_ok;
    logic                   wb_acc;
    logic                   wb_wr;
    logic [31:0]            rd_data;
    logic                   unused_wdat;
    irq_state_t             state;
    irq_state_t             state_nxt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_edge_sync u_sync (
            .clk  (clk),
            .rst  (rst),
            .src  (irq_src[i]),
            .rise (rise[i])
        );
    end

    // Mask edges until the history flops hold post-reset samples, so a source
    // already high at release is not taken as a fresh edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_cnt <= 2'(SETTLE_CYCLES);
        end else if (settle_cnt != 2'd0) begin
            settle_cnt <= settle_cnt - 2'd1;
        end
    end

    assign edge_ok     = (settle_cnt == 2'd0);
    assign wb_acc      = wb_stb_s & wb_cyc_s & ~wb_ack_s;
    assign wb_wr       = wb_acc & wb_we_s;
    assign unused_wdat = ^wb_dat_i;

    // Register read mux; bits beyond each field read as zero.
    always_comb begin
        rd_data = 32'd0;
        case (wb_adr_s)
            ADDR_ENABLE:  rd_data = 32'(enable);
            ADDR_PENDING: rd_data = 32'(pending);
            ADDR_VECBASE: rd_data = 32'(vecbase);
            ADDR_STATUS: begin
                rd_data[0]   = (state == ST_SERVICE);
                rd_data[7:4] = (state != ST_IDLE) ? idx : 4'd0;
            end
            default: rd_data = 32'd0;
        endcase
    end

    // Pending update: clears first, then new edges, so a coincident edge wins.
    always_comb begin
        pending_nxt = pending;
        ack_mask    = NUM_SRC'(1) << idx;
        if (wb_wr && wb_adr_s == ADDR_PENDING) begin
            pending_nxt = pending_nxt & ~wb_dat_i[NUM_SRC-1:0];
        end
        if (state == ST_REQ && interrutack) begin
            pending_nxt = pending_nxt & ~ack_mask;
        end
        pending_nxt = pending_nxt | (rise & {NUM_SRC{edge_ok}});
    end

    // Next-state logic; idx and vector only change when leaving IDLE.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        vec_nxt   = interuptadr;
        req_vec   = 16'(pending & enable);
        case (state)
            ST_IDLE: begin
                if (req_vec != 16'd0) begin
                    state_nxt = ST_REQ;
                    idx_nxt   = lowest_set(req_vec);
                    vec_nxt   = vecbase + (pc_bit_size'(idx_nxt) << VEC_SHIFT);
                end
            end
            ST_REQ: begin
                if (interrutack) state_nxt = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (exitint) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Controller state, latched request and registered core-side outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            idx         <= 4'd0;
            interuptadr <= '0;
            cpu_irq     <= 1'b0;
            pending     <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            interuptadr <= vec_nxt;
            cpu_irq     <= (state_nxt == ST_REQ);
            pending     <= pending_nxt;
        end
    end

    // Software-writable registers and the Wishbone response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable   <= '0;
            vecbase  <= pc_bit_size'(VEC_RESET);
            wb_ack_s <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            if (wb_wr && wb_adr_s == ADDR_ENABLE)  enable  <= wb_dat_i[NUM_SRC-1:0];
            if (wb_wr && wb_adr_s == ADDR_VECBASE) vecbase <= pc_bit_size'(wb_dat_i);
            wb_ack_s <= wb_acc;
            wb_dat_o <= wb_acc ? rd_data : 32'd0;
        end
    end

endmodule
